// File: rtl/nor2_chk_pkg.sv
// Shared types and helpers for the NOR2 stimulus-and-check stage.
package nor2_chk_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } chk_state_t;

  localparam int NUM_PATTERNS = 4;

  // Ideal two-input NOR response used as the golden value for each pattern.
  function automatic logic nor2_expected(input logic in1, input logic in2);
    return ~(in1 | in2);
  endfunction

endpackage

// File: rtl/nor2_vector_checker_if.sv
// Stimulus/response bundle between the checker and the harness around the NOR cell.
interface nor2_vector_checker_if;
  logic       start;
  logic       b;
  logic       in1;
  logic       in2;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_count;
  logic [3:0] fail_mask;

  // Harness side: launches runs and supplies the NOR output.
  modport master (
    output start, b,
    input  in1, in2, busy, done, pass, err_count, fail_mask
  );

  // Checker side.
  modport slave (
    input  start, b,
    output in1, in2, busy, done, pass, err_count, fail_mask
  );
endinterface

// File: rtl/nor2_chk_settle_timer.sv
// Loadable 4-bit down-counter that marks the end of a pattern's settle window.
module nor2_chk_settle_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] count;

  // Load has priority; decrement stops at zero so the flag stays valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != 4'd0)) begin
      count <= count - 4'd1;
    end
  end

  assign zero = (count == 4'd0);

endmodule

// File: rtl/nor2_vector_checker.sv
// Drives all four NOR input patterns, waits a settle window per pattern,
// samples b and accumulates a per-pattern failure mask.
//
//   state  | meaning
//   IDLE   | waiting for start, outputs at reset values
//   SETTLE | current pattern driven, settle counter running
//   SAMPLE | compare b against the ideal NOR of the driven pattern
//   DONE   | results held, done=1, inputs parked at 00
module nor2_vector_checker
  import nor2_chk_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  nor2_vector_checker_if.slave  bus
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

  chk_state_t state;
  logic [1:0] idx;
  logic       timer_load;
  logic       timer_dec;
  logic       timer_zero;
  logic       mismatch;
  logic       launch;

  // A run may be launched only from IDLE or DONE; start while busy is ignored.
  assign launch     = bus.start && ((state == IDLE) || (state == DONE));
  assign timer_load = launch || ((state == SAMPLE) && (idx != 2'd3));
  assign timer_dec  = (state == SETTLE);

  // Case inequality so an undriven (Z) or unknown (X) b counts as a failure.
  assign mismatch = (bus.b !== nor2_expected(bus.in1, bus.in2));

  nor2_chk_settle_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (SETTLE_LOAD),
    .dec      (timer_dec),
    .zero     (timer_zero)
  );

  // Sequencer: pattern stepping, result accumulation and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= 2'd0;
      bus.in1       <= 1'b0;
      bus.in2       <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.pass      <= 1'b0;
      bus.err_count <= 3'd0;
      bus.fail_mask <= 4'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state         <= SETTLE;
            idx           <= 2'd0;
            bus.in1       <= 1'b0;
            bus.in2       <= 1'b0;
            bus.busy      <= 1'b1;
            bus.done      <= 1'b0;
            bus.pass      <= 1'b0;
            bus.err_count <= 3'd0;
            bus.fail_mask <= 4'd0;
          end
        end
        SETTLE: begin
          if (timer_zero) begin
            state <= SAMPLE;
          end
        end
        SAMPLE: begin
          if (mismatch) begin
            bus.fail_mask[idx] <= 1'b1;
            bus.err_count      <= bus.err_count + 3'd1;
          end
          if (idx == 2'(NUM_PATTERNS - 1)) begin
            state    <= DONE;
            bus.in1  <= 1'b0;
            bus.in2  <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            bus.pass <= (bus.err_count == 3'd0) && !mismatch;
          end else begin
            state              <= SETTLE;
            idx                <= idx + 2'd1;
            {bus.in1, bus.in2} <= idx + 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nor2_vector_checker.sv
// Bench for nor2_vector_checker: two instances (default settle and zero settle),
// a cycle-level arithmetic model of a run, and directed plus random runs.
module tb_nor2_vector_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst_v   = 2'b11;
  logic [1:0] start_v = 2'b00;
  logic [1:0] rnd_b   = 2'b00;
  int         mode [2] = '{0, 0};
  bit         chk_en = 1'b0;

  int vectors     = 0;
  int miscompares = 0;

  nor2_vector_checker_if if0 ();
  nor2_vector_checker_if if1 ();

  // b source per instance: 0 ideal, 1 stuck-1, 2 stuck-0, 3 Z, 4 X, 5 random, 6 inverted
  function automatic logic bval(input int md, input logic a, input logic c, input logic r);
    case (md)
      0:       return ~(a | c);
      1:       return 1'b1;
      2:       return 1'b0;
      3:       return 1'bz;
      4:       return 1'bx;
      5:       return r;
      default: return a | c;
    endcase
  endfunction

  assign if0.start = start_v[0];
  assign if1.start = start_v[1];
  assign if0.b     = bval(mode[0], if0.in1, if0.in2, rnd_b[0]);
  assign if1.b     = bval(mode[1], if1.in1, if1.in2, rnd_b[1]);

  nor2_vector_checker #(.SETTLE_CYCLES(2)) dut0 (.clk(clk), .rst(rst_v[0]), .bus(if0.slave));
  nor2_vector_checker #(.SETTLE_CYCLES(0)) dut1 (.clk(clk), .rst(rst_v[1]), .bus(if1.slave));

  always @(posedge clk) begin
    #1;
    rnd_b = 2'($urandom);
  end

  // Model: a run is n edges since the accepted start; pattern = n / P, P = settle+2.
  int         per    [2] = '{4, 2};
  bit         m_act  [2] = '{0, 0};
  int         m_n    [2] = '{0, 0};
  bit         m_done [2] = '{0, 0};
  bit         m_pass [2] = '{0, 0};
  int         m_err  [2] = '{0, 0};
  logic [3:0] m_mask [2] = '{4'd0, 4'd0};

  task automatic model_step(input int k, input logic st, input logic r, input logic bb);
    int         p;
    logic [1:0] pp;
    logic       e;
    if (r) begin
      m_act[k] = 0; m_n[k] = 0; m_done[k] = 0; m_pass[k] = 0; m_err[k] = 0; m_mask[k] = 4'd0;
    end else if (st && !m_act[k]) begin
      m_act[k] = 1; m_n[k] = 0; m_done[k] = 0; m_pass[k] = 0; m_err[k] = 0; m_mask[k] = 4'd0;
    end else if (m_act[k]) begin
      m_n[k] = m_n[k] + 1;
      if (m_n[k] % per[k] == 0) begin
        p  = m_n[k] / per[k] - 1;
        pp = 2'(p);
        e  = !(pp[1] | pp[0]);
        if (bb !== e) begin
          m_mask[k][p] = 1'b1;
          m_err[k]     = m_err[k] + 1;
        end
      end
      if (m_n[k] == 4 * per[k]) begin
        m_act[k]  = 0;
        m_done[k] = 1;
        m_pass[k] = (m_err[k] == 0);
      end
    end
  endtask

  // Vector layout: {in1,in2,busy,done,pass,err_count[2:0],fail_mask[3:0]}
  function automatic logic [11:0] model_vec(input int k);
    logic [1:0] pin;
    pin = m_act[k] ? 2'(m_n[k] / per[k]) : 2'b00;
    return {pin, m_act[k], m_done[k], m_pass[k], 3'(m_err[k]), m_mask[k]};
  endfunction

  function automatic logic [11:0] dut_vec(input int k);
    if (k == 0)
      return {if0.in1, if0.in2, if0.busy, if0.done, if0.pass, if0.err_count, if0.fail_mask};
    return {if1.in1, if1.in2, if1.busy, if1.done, if1.pass, if1.err_count, if1.fail_mask};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare the state after the last edge, then advance the model with the inputs the next edge will see.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) chk($sformatf("cycle_k%0d", k), 32'(dut_vec(k)), 32'(model_vec(k)));
    end
    model_step(0, start_v[0], rst_v[0], if0.b);
    model_step(1, start_v[1], rst_v[1], if1.b);
  end

  logic [1:0] pat_log [64];

  // Pulse start (caller is just after a rising edge), then count edges after E0 until done.
  task automatic do_run(input int k, input int md, output int cyc);
    logic [11:0] v;
    mode[k]    = md;
    start_v[k] = 1'b1;
    @(posedge clk); #1;
    start_v[k] = 1'b0;
    v = dut_vec(k);
    chk("busy_after_start", 32'(v[9]), 32'd1);
    chk("done_drop", 32'(v[8]), 32'd0);
    pat_log[0] = v[11:10];
    cyc = 0;
    while (cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      v = dut_vec(k);
      pat_log[cyc] = v[11:10];
      if (v[8]) break;
    end
    if (!v[8]) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic chk_result(input string nm, input int k, input int cyc, input int exp_cyc,
                            input bit exp_pass, input int exp_err, input logic [3:0] exp_mask);
    logic [11:0] v;
    v = dut_vec(k);
    chk({nm, "_cycles"}, 32'(cyc), 32'(exp_cyc));
    chk({nm, "_pass"}, 32'(v[7]), 32'(exp_pass));
    chk({nm, "_err"}, 32'(v[6:4]), 32'(exp_err));
    chk({nm, "_mask"}, 32'(v[3:0]), 32'(exp_mask));
  endtask

  initial begin
    int cyc;
    int k;
    int md;
    int abort_at;
    repeat (2) @(posedge clk);
    #1;
    rst_v  = 2'b00;
    chk_en = 1'b1;
    chk("reset_k0", 32'(dut_vec(0)), 32'd0);
    chk("reset_k1", 32'(dut_vec(1)), 32'd0);
    @(posedge clk); #1;

    // Ideal NOR, default settle: done at E0+16, patterns 00,01,10,11 held 4 cycles each.
    do_run(0, 0, cyc);
    chk_result("ideal", 0, cyc, 16, 1'b1, 0, 4'b0000);
    for (int i = 0; i < 16; i++) chk($sformatf("seq_%0d", i), 32'(pat_log[i]), 32'(i / 4));
    @(posedge clk); #1;

    do_run(0, 1, cyc);
    chk_result("stuck1", 0, cyc, 16, 1'b0, 3, 4'b1110);

    // Z / X on b: a 4-state simulator sees every pattern fail; a 2-state one sees stuck-at-0.
    do_run(0, 3, cyc);
    if ($isunknown(if0.b)) chk_result("bz", 0, cyc, 16, 1'b0, 4, 4'b1111);
    else                   chk_result("bz", 0, cyc, 16, 1'b0, 1, 4'b0001);
    do_run(0, 4, cyc);
    if ($isunknown(if0.b)) chk_result("bx", 0, cyc, 16, 1'b0, 4, 4'b1111);
    else                   chk_result("bx", 0, cyc, 16, 1'b0, 1, 4'b0001);

    do_run(0, 6, cyc);
    chk_result("inverted", 0, cyc, 16, 1'b0, 4, 4'b1111);

    // Zero settle: done at E0+8, then restart straight from DONE.
    do_run(1, 0, cyc);
    chk_result("s0_first", 1, cyc, 8, 1'b1, 0, 4'b0000);
    do_run(1, 0, cyc);
    chk_result("s0_second", 1, cyc, 8, 1'b1, 0, 4'b0000);
    do_run(1, 2, cyc);
    chk_result("s0_stuck0", 1, cyc, 8, 1'b0, 1, 4'b0001);

    // Stuck-at-0 run with start held E0..E0+5, reset sampled at E0+6.
    mode[0]    = 2;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    repeat (5) begin @(posedge clk); #1; end
    chk("held_start_pattern", 32'({if0.in1, if0.in2}), 32'd1);
    chk("held_start_busy", 32'(if0.busy), 32'd1);
    chk("held_start_mask", 32'(if0.fail_mask), 32'b0001);
    start_v[0] = 1'b0;
    rst_v[0]   = 1'b1;
    @(posedge clk); #1;
    rst_v[0] = 1'b0;
    chk("midrun_reset", 32'(dut_vec(0)), 32'd0);
    @(posedge clk); #1;
    do_run(0, 0, cyc);
    chk_result("after_reset", 0, cyc, 16, 1'b1, 0, 4'b0000);

    // Random runs with stray starts and occasional mid-run resets; the per-cycle compare judges them.
    for (int r = 0; r < 40; r++) begin
      k        = int'($urandom_range(0, 1));
      md       = int'($urandom_range(0, 6));
      abort_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 4 * per[k])) : -1;
      mode[k]    = md;
      start_v[k] = 1'b1;
      @(posedge clk); #1;
      for (int c = 1; c <= 4 * per[k] + 2; c++) begin
        start_v[k] = ($urandom_range(0, 5) == 0);
        rst_v[k]   = (c == abort_at);
        @(posedge clk); #1;
      end
      start_v[k] = 1'b0;
      rst_v[k]   = 1'b0;
      repeat (int'($urandom_range(0, 2))) begin @(posedge clk); #1; end
    end

    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nor2_vector_checker.md
# nor2_vector_checker

Stimulus-and-check stage wrapped around the 2-input NMOS NOR cell. It drives `in1`/`in2` into the NOR through all four input patterns, waits a programmable settle time per pattern, samples the NOR output `b` and compares it against the ideal NOR function. It reports pass/fail and a per-pattern failure mask. It sits directly upstream (drives the inputs) and downstream (consumes `b`) of the NOR cell in the gate-level test harness.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 2: extra cycles each pattern is held before sampling. Legal range 0..15.

Ports (one clock; reset is synchronous and active-high):
- `clk`  input  1  rising-edge clock
- `rst`  input  1  synchronous, active-high reset
- `start`  input  1  begin a run; honoured only in IDLE or DONE
- `b`  input  1  NOR cell output under test (4-state; X/Z possible)
- `in1`  output  1  NOR input 1, registered
- `in2`  output  1  NOR input 2, registered
- `busy`  output  1  run in progress
- `done`  output  1  run complete; level, held until next `start` or `rst`
- `pass`  output  1  valid when `done`=1; 1 iff no pattern failed
- `err_count`  output  3  failed patterns, 0..4
- `fail_mask`  output  4  bit i set ⇒ pattern i failed (pattern i: `in1`=i[1], `in2`=i[0])

## Operation
- Reset values: `in1`=0, `in2`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `fail_mask`=0, state IDLE.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
  - IDLE: `start`=1 → SETTLE. Pattern index=0, `in1`/`in2`=00, settle counter=SETTLE_CYCLES, `err_count`/`fail_mask` cleared, `busy`=1.
  - SETTLE: counter>0 → decrement, stay; counter==0 → SAMPLE. With SETTLE_CYCLES=0, SETTLE lasts one cycle.
  - SAMPLE: expected = ~(`in1`|`in2`). Mismatch → set `fail_mask`[index] and increment `err_count`. Mismatch uses 4-state inequality, so `b`=X or Z is a failure (e.g. a missing pull-up). Index<3 → index+1, drive the new pattern, reload the counter, go to SETTLE. Index==3 → DONE.
  - DONE: `busy`=0, `done`=1, `pass`=(`err_count`==0), `in1`/`in2`=00. `start`=1 behaves exactly as in IDLE and drops `done`/`pass` on the same edge.
- `start` while `busy` is ignored.
- `rst` mid-run: all outputs return to reset values on that edge; partial results are discarded.
- `err_count` saturates naturally at 4. No wrap is possible.

## Timing
- `start` sampled at edge E0. Pattern 0 is visible on `in1`/`in2` after E0.
- Each pattern is held SETTLE_CYCLES+2 cycles (SETTLE_CYCLES+1 in SETTLE, 1 in SAMPLE).
- `b` is compared at the edge that ends SAMPLE.
- `done`=1 after edge E0 + 4·(SETTLE_CYCLES+2). For the default this is E0+16.
- Outputs change only on rising `clk` edges. There is no combinational path from `b` or `start` to any output.

## Structure
- Package `nor2_chk_pkg`:
  - state enum `chk_state_t`
  - constant `NUM_PATTERNS`=4
  - function `nor2_expected(in1,in2)`
- One sub-module, `nor2_chk_settle_timer`: loadable down-counter with a `zero` flag, width 4. All other logic lives in the top FSM.

## Test plan
- Ideal NOR model on `b`, default parameter: `start` pulse → `done`=1 at E0+16, `pass`=1, `err_count`=0, `fail_mask`=0000, `in1`/`in2` sequence 00,01,10,11 each held 4 cycles.
- `b` stuck-at-1: → `pass`=0, `err_count`=3, `fail_mask`=1110.
- `b`=Z always (pull-up removed): → `err_count`=4, `fail_mask`=1111; with `b`=X → same result.
- SETTLE_CYCLES=0, ideal model: → `done` at E0+8, `pass`=1. Then a second `start` in DONE → `done` drops the next cycle and a new run completes at +8.
- `rst` asserted at E0+6 during a stuck-at-0 run → all outputs 0 next edge, state IDLE. `start` held during the run (E0+1..E0+5) → no restart and no change in pattern timing.
